// File: rtl/conv2d_pkg.sv
// Shared Conv2d types: kernel-load write-state encodings and default channel width.
package conv2d_pkg;

  localparam int CH_W_DEF = 9;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_LOAD = 2'd1,
    W_DONE = 2'd2
  } wstate_t;

endpackage

// File: rtl/kernel_addr_counter.sv
// Word-address counter with sync clear (priority over enable) and terminal-count compare.
module kernel_addr_counter
  import conv2d_pkg::*;
#(
  parameter int CH_W = CH_W_DEF
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            clr,
  input  logic            en,
  input  logic [CH_W-1:0] term,
  output logic [CH_W-1:0] count,
  output logic            at_term
);

  always_ff @(posedge clk) begin
    if (!Reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/kernel_bram_pingpong_ctrl.sv
// Ping-pong kernel BRAM controller: loads one kernel per request into the free bank
// from AXI-Stream while the conv engine walks the other bank word by word.
module kernel_bram_pingpong_ctrl
  import conv2d_pkg::*;
#(
  parameter int CH_W    = CH_W_DEF,
  parameter int NBANK_W = 1
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic [CH_W-1:0]         CHANNEL_SIZE,
  input  logic                    load_req,
  output logic                    load_ready,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic                    wea,
  output logic [CH_W+NBANK_W-1:0] addra,
  output logic                    load_done,
  output logic                    tlast_err,
  input  logic                    rd_advance,
  output logic                    rd_valid,
  output logic                    enb,
  output logic [CH_W+NBANK_W-1:0] addrb,
  output logic                    last_channel
);

  wstate_t         wstate;
  logic            run;
  logic [CH_W-1:0] size_wr;
  logic            wr_bank;
  logic [CH_W-1:0] wr_addr;
  logic            wr_at_term;
  logic            load_accept;

  logic [1:0]      bank_full;
  logic            rd_bank;
  logic [CH_W-1:0] size_bank [2];
  logic [CH_W-1:0] size_rd;
  logic [CH_W-1:0] rd_addr;
  logic            rd_at_term;
  logic            rd_step;
  logic            rd_release;

  // run keeps load_ready low through the reset cycle itself
  always_ff @(posedge clk) begin
    if (!Reset) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  assign load_ready  = run && (wstate == W_IDLE) && (bank_full != 2'b11);
  assign load_accept = load_req && load_ready;
  assign wea         = s_axis_tvalid && s_axis_tready;
  assign addra       = {wr_bank, wr_addr};

  always_ff @(posedge clk) begin
    if (!Reset) begin
      wstate        <= W_IDLE;
      size_wr       <= '0;
      wr_bank       <= 1'b0;
      s_axis_tready <= 1'b0;
      load_done     <= 1'b0;
      tlast_err     <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (wstate)
        W_IDLE: begin
          if (load_accept) begin
            size_wr       <= (CHANNEL_SIZE == '0) ? CH_W'(1) : CHANNEL_SIZE;
            wr_bank       <= rd_valid ? ~rd_bank : rd_bank;
            tlast_err     <= 1'b0;
            s_axis_tready <= 1'b1;
            wstate        <= W_LOAD;
          end
        end
        W_LOAD: begin
          if (wea) begin
            if (wr_at_term) begin
              tlast_err     <= ~s_axis_tlast;
              s_axis_tready <= 1'b0;
              load_done     <= 1'b1;
              wstate        <= W_DONE;
            end else if (s_axis_tlast) begin
              // early tlast: drop the partial kernel, bank stays empty
              tlast_err     <= 1'b1;
              s_axis_tready <= 1'b0;
              wstate        <= W_IDLE;
            end
          end
        end
        W_DONE: begin
          wstate <= W_IDLE;
        end
        default: begin
          s_axis_tready <= 1'b0;
          wstate        <= W_IDLE;
        end
      endcase
    end
  end

  // Address freezes on the final word so addra still points at it during W_DONE
  kernel_addr_counter #(.CH_W(CH_W)) u_wr_cnt (
    .clk     (clk),
    .Reset   (Reset),
    .clr     (load_accept),
    .en      (wea && !wr_at_term),
    .term    (size_wr - 1'b1),
    .count   (wr_addr),
    .at_term (wr_at_term)
  );

  assign size_rd      = size_bank[rd_bank];
  assign rd_valid     = bank_full[rd_bank];
  assign enb          = rd_valid;
  assign addrb        = {rd_bank, rd_addr};
  assign last_channel = rd_valid && rd_at_term;
  assign rd_step      = rd_advance && rd_valid && !rd_at_term;
  assign rd_release   = rd_advance && last_channel;

  kernel_addr_counter #(.CH_W(CH_W)) u_rd_cnt (
    .clk     (clk),
    .Reset   (Reset),
    .clr     (rd_release),
    .en      (rd_step),
    .term    (size_rd - 1'b1),
    .count   (rd_addr),
    .at_term (rd_at_term)
  );

  // Release and load completion always target different banks, so both apply
  always_ff @(posedge clk) begin
    if (!Reset) begin
      bank_full    <= 2'b00;
      rd_bank      <= 1'b0;
      size_bank[0] <= '0;
      size_bank[1] <= '0;
    end else begin
      if (rd_release) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
      end
      if (wstate == W_DONE) begin
        bank_full[wr_bank] <= 1'b1;
        size_bank[wr_bank] <= size_wr;
      end
    end
  end

endmodule
